// File: rtl/phy_rx_pkg.sv
// rtl/phy_rx_pkg.sv - shared symbols, state encodings and counter widths for the PHY receive sync path
package phy_rx_pkg;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;

    localparam int CNT_W = 4;
    localparam int ERR_W = 8;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2,
        ST_HOLD   = 2'd3
    } rx_state_e;

endpackage

// File: rtl/rx_err_counter.sv
// rtl/rx_err_counter.sv - 8-bit saturating loss counter, present only when RX_ERR_CNT_EN is defined
`ifdef RX_ERR_CNT_EN
import phy_rx_pkg::*;

module rx_err_counter (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [ERR_W-1:0] count
);

    logic [ERR_W-1:0] count_q;
    logic [ERR_W-1:0] count_d;

    // Increment on request, sticking at all-ones instead of wrapping
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {ERR_W{1'b1}})) begin
            count_d = count_q + {{(ERR_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`endif

// File: rtl/phy_rx_sync_ctrl.sv
// rtl/phy_rx_sync_ctrl.sv - COM alignment, lock tracking and control stripping; optional loss counter via RX_ERR_CNT_EN
import phy_rx_pkg::*;

module phy_rx_sync_ctrl #(
    parameter int COM_COUNT  = 4,
    parameter int LOSS_COUNT = 4
) (
    input  logic             clk_4f,
    input  logic             reset,
    input  logic [7:0]       sp_in,
    input  logic             valid_in,
    input  logic             active_in,
    output logic [7:0]       data_out,
    output logic             valid_out,
    output logic             link_up,
    output logic             idle_out,
    output logic [1:0]       state_out,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] COM_LIM  = CNT_W'(COM_COUNT);
    localparam logic [CNT_W-1:0] LOSS_LIM = CNT_W'(LOSS_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] com_cnt_q, com_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0] miss_next;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             idle_q, idle_d;

    // Next-state, counters and output decisions; active_in low overrides everything
    always_comb begin
        state_d    = state_q;
        com_cnt_d  = com_cnt_q;
        miss_cnt_d = miss_cnt_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        idle_d     = idle_q;
        miss_next  = (state_q == ST_HOLD) ? (miss_cnt_q + CNT_ONE) : CNT_ONE;

        if (!active_in) begin
            state_d    = ST_SEARCH;
            com_cnt_d  = '0;
            miss_cnt_d = '0;
            idle_d     = 1'b0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (valid_in && (sp_in == COM)) begin
                        state_d   = ST_ALIGN;
                        com_cnt_d = CNT_ONE;
                    end
                end
                ST_ALIGN: begin
                    if (valid_in && (sp_in == COM)) begin
                        if ((com_cnt_q + CNT_ONE) == COM_LIM) begin
                            state_d   = ST_LOCKED;
                            com_cnt_d = '0;
                        end else begin
                            com_cnt_d = com_cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d   = ST_SEARCH;
                        com_cnt_d = '0;
                    end
                end
                ST_LOCKED, ST_HOLD: begin
                    if (valid_in) begin
                        // A returning byte in HOLD is classified on the same edge as in LOCKED
                        state_d    = ST_LOCKED;
                        miss_cnt_d = '0;
                        if (sp_in == IDL) begin
                            idle_d = 1'b1;
                        end else if (sp_in != COM) begin
                            data_d  = sp_in;
                            valid_d = 1'b1;
                            idle_d  = 1'b0;
                        end
                    end else if (miss_next == LOSS_LIM) begin
                        state_d    = ST_SEARCH;
                        miss_cnt_d = '0;
                        idle_d     = 1'b0;
                    end else begin
                        state_d    = ST_HOLD;
                        miss_cnt_d = miss_next;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state_q    <= ST_SEARCH;
            com_cnt_q  <= '0;
            miss_cnt_q <= '0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            idle_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            com_cnt_q  <= com_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            idle_q     <= idle_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign idle_out  = idle_q;
    assign state_out = state_q;
    assign link_up   = (state_q == ST_LOCKED) || (state_q == ST_HOLD);

`ifdef RX_ERR_CNT_EN
    logic err_inc;
    assign err_inc = ((state_q == ST_LOCKED) || (state_q == ST_HOLD)) && !valid_in;

    rx_err_counter u_err_counter (
        .clk   (clk_4f),
        .rst   (reset),
        .inc   (err_inc),
        .count (err_count)
    );
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// tb/tb_phy_rx_sync_ctrl.sv - scoreboard bench for phy_rx_sync_ctrl with default and COM_COUNT=2/LOSS_COUNT=1 instances
module tb_phy_rx_sync_ctrl;

    logic       clk_4f = 1'b0;
    logic       reset  = 1'b1;

    logic [7:0] sp_a = 8'h00;
    logic       vin_a = 1'b0;
    logic       act_a = 1'b1;
    logic [7:0] dout_a;
    logic       vout_a, link_a, idle_a;
    logic [1:0] st_a;
    logic [7:0] err_a;

    logic [7:0] sp_b = 8'h00;
    logic       vin_b = 1'b0;
    logic       act_b = 1'b1;
    logic [7:0] dout_b;
    logic       vout_b, link_b, idle_b;
    logic [1:0] st_b;
    logic [7:0] err_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    always #5 clk_4f = ~clk_4f;

    phy_rx_sync_ctrl #(.COM_COUNT(4), .LOSS_COUNT(4)) u_dut_a (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .sp_in     (sp_a),
        .valid_in  (vin_a),
        .active_in (act_a),
        .data_out  (dout_a),
        .valid_out (vout_a),
        .link_up   (link_a),
        .idle_out  (idle_a),
        .state_out (st_a),
        .err_count (err_a)
    );

    phy_rx_sync_ctrl #(.COM_COUNT(2), .LOSS_COUNT(1)) u_dut_b (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .sp_in     (sp_b),
        .valid_in  (vin_b),
        .active_in (act_b),
        .data_out  (dout_b),
        .valid_out (vout_b),
        .link_up   (link_b),
        .idle_out  (idle_b),
        .state_out (st_b),
        .err_count (err_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one byte into the selected instance (0 = A, 1 = B); the other sees valid_in low
    task automatic drive(input int sel, input logic v, input logic [7:0] b, input logic act);
        @(negedge clk_4f);
        if (sel == 0) begin
            sp_a = b; vin_a = v; act_a = act; vin_b = 1'b0; act_b = 1'b1;
        end else begin
            sp_b = b; vin_b = v; act_b = act; vin_a = 1'b0; act_a = 1'b1;
        end
        @(posedge clk_4f);
        #1;
    endtask

    task automatic send_payload(input int sel, input logic [7:0] b);
        if (sel == 0) q_a.push_back(b);
        else          q_b.push_back(b);
        drive(sel, 1'b1, b, 1'b1);
    endtask

    // Monitor A: every forwarded byte must match the oldest expected payload
    always @(negedge clk_4f) begin
        if (!reset && vout_a) begin
            if (q_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out_a: got 0x%0h expected none", dout_a);
            end else begin
                chk("payload_a", {24'h0, dout_a}, {24'h0, q_a.pop_front()});
            end
        end
    end

    // Monitor B: same scoreboard for the short-lock instance
    always @(negedge clk_4f) begin
        if (!reset && vout_b) begin
            if (q_b.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out_b: got 0x%0h expected none", dout_b);
            end else begin
                chk("payload_b", {24'h0, dout_b}, {24'h0, q_b.pop_front()});
            end
        end
    end

    initial begin
        logic [7:0] err_exp;
`ifdef RX_ERR_CNT_EN
        err_exp = 8'd7;
`else
        err_exp = 8'd0;
`endif
        #12;
        chk("rst_state_a", {30'h0, st_a}, 32'd0);
        chk("rst_link_a", {31'h0, link_a}, 32'd0);
        chk("rst_data_a", {24'h0, dout_a}, 32'h00);
        chk("rst_valid_a", {31'h0, vout_a}, 32'd0);
        chk("rst_err_a", {24'h0, err_a}, 32'd0);
        @(negedge clk_4f);
        reset = 1'b0;

        // Lock: four COMs, then two payload bytes
        drive(0, 1'b1, 8'hBC, 1'b1);
        chk("align_state", {30'h0, st_a}, 32'd1);
        drive(0, 1'b1, 8'hBC, 1'b1);
        drive(0, 1'b1, 8'hBC, 1'b1);
        chk("no_lock_3com", {31'h0, link_a}, 32'd0);
        drive(0, 1'b1, 8'hBC, 1'b1);
        chk("lock_4com", {31'h0, link_a}, 32'd1);
        chk("lock_state", {30'h0, st_a}, 32'd2);
        chk("lock_com_not_fwd", {31'h0, vout_a}, 32'd0);
        send_payload(0, 8'h12);
        chk("lat_valid", {31'h0, vout_a}, 32'd1);
        send_payload(0, 8'h34);

        // active_in drop mid-payload
        send_payload(0, 8'h56);
        drive(0, 1'b1, 8'h99, 1'b0);
        chk("act_drop_state", {30'h0, st_a}, 32'd0);
        chk("act_drop_link", {31'h0, link_a}, 32'd0);
        chk("act_drop_valid", {31'h0, vout_a}, 32'd0);
        chk("act_drop_hold_data", {24'h0, dout_a}, 32'h56);

        // Broken alignment
        drive(0, 1'b1, 8'hBC, 1'b1);
        drive(0, 1'b1, 8'hBC, 1'b1);
        drive(0, 1'b1, 8'h55, 1'b1);
        chk("broken_search", {30'h0, st_a}, 32'd0);
        for (int i = 0; i < 3; i++) drive(0, 1'b1, 8'hBC, 1'b1);
        chk("broken_no_lock", {31'h0, link_a}, 32'd0);
        drive(0, 1'b1, 8'hBC, 1'b1);
        chk("broken_relock", {30'h0, st_a}, 32'd2);

        // Control stripping
        send_payload(0, 8'hAA);
        chk("idle_after_pay", {31'h0, idle_a}, 32'd0);
        drive(0, 1'b1, 8'h7C, 1'b1);
        chk("idle_set", {31'h0, idle_a}, 32'd1);
        chk("idl_not_fwd", {31'h0, vout_a}, 32'd0);
        drive(0, 1'b1, 8'hBC, 1'b1);
        chk("idle_keep_com", {31'h0, idle_a}, 32'd1);
        send_payload(0, 8'h01);
        chk("idle_clear", {31'h0, idle_a}, 32'd0);

        // Loss and recovery
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b0, 8'h00, 1'b1);
            chk("hold_state", {30'h0, st_a}, 32'd3);
            chk("hold_link", {31'h0, link_a}, 32'd1);
        end
        send_payload(0, 8'h77);
        chk("recover_state", {30'h0, st_a}, 32'd2);
        for (int i = 0; i < 3; i++) drive(0, 1'b0, 8'h00, 1'b1);
        chk("hold_before_loss", {30'h0, st_a}, 32'd3);
        drive(0, 1'b0, 8'h00, 1'b1);
        chk("loss_state", {30'h0, st_a}, 32'd0);
        chk("loss_link", {31'h0, link_a}, 32'd0);
        chk("err_count_a", {24'h0, err_a}, {24'h0, err_exp});

        // Async reset between edges while locked
        for (int i = 0; i < 4; i++) drive(0, 1'b1, 8'hBC, 1'b1);
        send_payload(0, 8'h21);
        #6;
        reset = 1'b1;
        #1;
        chk("async_state_a", {30'h0, st_a}, 32'd0);
        chk("async_link_a", {31'h0, link_a}, 32'd0);
        chk("async_data_a", {24'h0, dout_a}, 32'h00);
        chk("async_valid_a", {31'h0, vout_a}, 32'd0);
        chk("async_err_a", {24'h0, err_a}, 32'd0);
        @(negedge clk_4f);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) drive(0, 1'b1, 8'hBC, 1'b1);
        chk("relock_not_yet", {31'h0, link_a}, 32'd0);
        drive(0, 1'b1, 8'hBC, 1'b1);
        chk("relock_a", {31'h0, link_a}, 32'd1);

        // Short-lock instance: COM_COUNT=2, LOSS_COUNT=1
        drive(1, 1'b1, 8'hBC, 1'b1);
        chk("b_align", {30'h0, st_b}, 32'd1);
        drive(1, 1'b1, 8'hBC, 1'b1);
        chk("b_lock", {31'h0, link_b}, 32'd1);
        send_payload(1, 8'h42);
        drive(1, 1'b0, 8'h00, 1'b1);
        chk("b_loss_direct", {30'h0, st_b}, 32'd0);
        drive(1, 1'b1, 8'hBC, 1'b1);
        drive(1, 1'b1, 8'hBC, 1'b1);
        send_payload(1, 8'h43);
        #6;
        reset = 1'b1;
        #1;
        chk("b_async_state", {30'h0, st_b}, 32'd0);
        chk("b_async_data", {24'h0, dout_b}, 32'h00);
        chk("b_async_link", {31'h0, link_b}, 32'd0);
        @(negedge clk_4f);
        reset = 1'b0;
        drive(1, 1'b1, 8'hBC, 1'b1);
        chk("b_relock_not_yet", {31'h0, link_b}, 32'd0);
        drive(1, 1'b1, 8'hBC, 1'b1);
        chk("b_relock", {31'h0, link_b}, 32'd1);

        drive(1, 1'b0, 8'h00, 1'b1);
        drive(1, 1'b0, 8'h00, 1'b1);
        chk("sb_drained_a", q_a.size(), 32'd0);
        chk("sb_drained_b", q_b.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
